// File: rtl/mips_fetch_if.sv
// Fetch-stage bus: instruction memory port, decode handshake and execute redirect.
// MIPS_FETCH_MISALIGN_TRAP_EN adds the fetch_fault signal.
interface mips_fetch_if;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic [29:0] imem_addr;
  logic        imem_en_c;
  logic [31:0] imem_data;
  logic [31:0] pc_addr;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
`ifdef MIPS_FETCH_MISALIGN_TRAP_EN
  logic        fetch_fault;
`endif

  modport master (
    input  redirect, redirect_addr, imem_data, inst_ready,
`ifdef MIPS_FETCH_MISALIGN_TRAP_EN
    output fetch_fault,
`endif
    output imem_addr, imem_en_c, pc_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect, redirect_addr, imem_data, inst_ready,
`ifdef MIPS_FETCH_MISALIGN_TRAP_EN
    input  fetch_fault,
`endif
    input  imem_addr, imem_en_c, pc_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/mips_fetch.sv
// MIPS instruction fetch: PC generation, sync imem read, 2-entry decode queue.
// Optional misaligned-redirect trap under MIPS_FETCH_MISALIGN_TRAP_EN.
module mips_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mips_fetch_if.master bus_io
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 2;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0]    pc_q, pc_d;
  entry_t [DEPTH-1:0] q_q, q_d;
  logic [CW-1:0]      count_q, count_d;
  logic               inflight_q, inflight_d;
  logic [XLEN-1:0]    inflight_pc_q, inflight_pc_d;
  logic               pop;
  logic               issue;
  logic               trap_c;
  logic [CW-1:0]      after_pop;

`ifdef MIPS_FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  assign trap_c             = fault_q;
  assign bus_io.fetch_fault = fault_q;
`else
  logic unused_addr_c;
  assign trap_c        = 1'b0;
  assign unused_addr_c = ^bus_io.redirect_addr[1:0];
`endif

  // Next-state: redirect flushes everything; otherwise pop, push return, maybe issue.
  always_comb begin
    pc_d          = pc_q;
    q_d           = q_q;
    count_d       = count_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    issue         = 1'b0;
    pop           = (count_q != '0) & bus_io.inst_ready;
    after_pop     = count_q - CW'(pop);
`ifdef MIPS_FETCH_MISALIGN_TRAP_EN
    fault_d       = fault_q;
`endif
    if (bus_io.redirect) begin
      count_d = '0;
      if (!trap_c) begin
        pc_d = {bus_io.redirect_addr[31:2], 2'b00};
      end
`ifdef MIPS_FETCH_MISALIGN_TRAP_EN
      fault_d = fault_q | (|bus_io.redirect_addr[1:0]);
`endif
    end else begin
      if (pop) begin
        q_d[0] = q_q[1];
      end
      // Issue rule guarantees the tail slot is free when a word returns
      if (inflight_q) begin
        q_d[after_pop[0]].data = bus_io.imem_data;
        q_d[after_pop[0]].pc   = inflight_pc_q;
      end
      count_d = after_pop + CW'(inflight_q);
      issue   = !trap_c && ((count_q + CW'(inflight_q) - CW'(pop)) < CW'(DEPTH));
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      q_q           <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
`ifdef MIPS_FETCH_MISALIGN_TRAP_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      pc_q          <= pc_d;
      q_q           <= q_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
`ifdef MIPS_FETCH_MISALIGN_TRAP_EN
      fault_q       <= fault_d;
`endif
    end
  end

  assign bus_io.imem_en_c  = issue & ~rst_i;
  assign bus_io.imem_addr  = pc_q[XLEN-1:2];
  assign bus_io.pc_addr    = pc_q;
  assign bus_io.inst_valid = (count_q != '0);
  assign bus_io.inst_data  = q_q[0].data;
  assign bus_io.inst_pc    = q_q[0].pc;
endmodule
